icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
- Read-only, direct-mapped instruction cache inside CHIP, between the RISC-V fetch stage and the off-chip slow instruction memory (slow_memI).
- Serves 32-bit instruction words to the core.
- On a miss, fetches one 128-bit line over the mem_read/mem_ready handshake and stalls the core until the word is available.
- The cache only ever reads, so mem_write is held low permanently.

Parameters:
- NUM_BLOCKS, 8, number of lines. Power of 2, 2 or more.
- INDEX_W, 3, equal to log2(NUM_BLOCKS).
- TAG_W, 25, equal to 28-INDEX_W. Tag = proc_addr[29:2+INDEX_W].

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- proc_read  in  1  fetch request, valid this cycle
- proc_write  in  1  unused; any value ignored
- proc_addr  in  30  word address of the instruction (byte address >> 2)
- proc_wdata  in  32  unused
- proc_rdata  out  32  instruction word; valid when proc_read=1 and proc_stall=0
- proc_stall  out  1  1 = core must hold proc_addr and retry
- mem_read  out  1  line read request to slow memory
- mem_write  out  1  constant 0
- mem_addr  out  28  line address = proc_addr[29:2]
- mem_rdata  in  128  returned line; word k sits in bits [32k+31:32k]
- mem_wdata  out  128  constant 0
- mem_ready  in  1  one-cycle pulse; line valid on mem_rdata in that cycle

Behaviour:
- Reset, while rst=1 at a rising edge:
  - all valid bits cleared; state goes to COMPARE.
  - mem_read=0 and proc_stall=0 from the following cycle.
  - tags and data are not reset.
- Index = proc_addr[INDEX_W+1:2]. Word offset = proc_addr[1:0].
- Hit = valid[index] and tag[index]==addr tag.
- State COMPARE:
  - proc_read=0: proc_stall=0, no state change.
  - proc_read=1 and hit: proc_stall=0 combinationally; proc_rdata = selected word in the same cycle (zero-latency hit).
  - proc_read=1 and miss: proc_stall=1 combinationally; latch the line address; next state ALLOCATE.
- State ALLOCATE:
  - mem_read=1 and proc_stall=1 every cycle, with mem_addr = latched line address.
  - mem_read stays high until mem_ready=1.
  - On mem_ready=1: write mem_rdata into data[index], set tag and valid; next state COMPARE.
  - mem_read drops to 0 in the cycle after mem_ready.
  - The core's retry then hits. Miss penalty = memory latency + 2 cycles.
- mem_addr outside ALLOCATE: proc_addr[29:2] (don't-care to memory, deterministic for equivalence).
- mem_ready=1 while in COMPARE (stale response after reset): ignored; arrays unchanged.
- proc_read drops during ALLOCATE: the fill still completes; there is no abort.
- proc_addr change during a stall: the cache uses the latched address, so the fill targets the original line. The core is required to hold the address.
- rst=1 during ALLOCATE:
  - fill abandoned, valid bits cleared, state COMPARE.
  - mem_read=0 from the next cycle.
- A refill to an occupied index overwrites the line; there is no write-back because lines are never dirty.

Decomposition:
- Shared package: line width 128, word width 32, memory line-address width 28, state encoding {COMPARE, ALLOCATE}.
- One sub-module, icache_line_array: tag/valid/data storage with one synchronous write port and combinational read.
  - Used by this block.
  - Reused later by a compressed-instruction fetch aligner.
- Controller FSM, hit logic and word mux stay in the top module.

Test Plan:
- Cold miss: after reset, proc_read=1, proc_addr=30'h0000_0004.
  - Expect proc_stall=1 and mem_read=1 with mem_addr=28'h000_0001.
  - Memory returns a line with word0=32'h0000_0013 after 4 cycles.
  - Expect mem_read=0 next cycle; retry gives proc_stall=0 and proc_rdata=32'h0000_0013.
- Same-line hits: proc_addr 30'h5, 30'h6, 30'h7 on consecutive cycles → proc_stall=0 each cycle, words 1-3 of that line, no mem_read.
- Conflict eviction: fetch 30'h0000_0000, then 30'h0000_0020 (same index 0, different tag).
  - Second fetch misses with mem_addr=28'h000_0008.
  - Refetch of 30'h0 misses again.
- Variable latency: mem_ready delayed 1, 7, then 20 cycles.
  - mem_read stays continuously high until mem_ready, drops the cycle after.
  - Data correct in all three cases.
- Reset mid-fill: assert rst for 1 cycle while in ALLOCATE.
  - Expect mem_read=0 next cycle.
  - A late mem_ready is ignored.
  - Next fetch of a previously cached line misses.
- Writes ignored: proc_write=1 with proc_wdata=32'hDEAD_BEEF → mem_write stays 0; a later read returns the original instruction.

Source files
------------

// File: rtl/icache_direct_mapped_pkg.sv
// Shared widths and controller state encoding for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int MEM_ADDR_W     = 28;
  localparam int PROC_ADDR_W    = 30;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic {
    COMPARE  = 1'b0,
    ALLOCATE = 1'b1
  } state_t;
endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache bundled as one bus.
interface icache_direct_mapped_if;
  import icache_direct_mapped_pkg::*;

  logic                   proc_read;
  logic                   proc_write;
  logic [PROC_ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]      proc_wdata;
  logic [WORD_W-1:0]      proc_rdata;
  logic                   proc_stall;
  logic                   mem_read;
  logic                   mem_write;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic [LINE_W-1:0]      mem_rdata;
  logic [LINE_W-1:0]      mem_wdata;
  logic                   mem_ready;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_line_array.sv
// Tag/valid/data storage: one synchronous write port, one combinational read port.
module icache_line_array
  import icache_direct_mapped_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = 3,
  parameter int TAG_W      = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line
);
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tags  [NUM_BLOCKS];
  logic [LINE_W-1:0]     lines [NUM_BLOCKS];

  // Only the valid bits are reset; stale tags/data are unreachable once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];
endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped I-cache: zero-latency hits, one 128-bit line refill per miss.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = 28 - INDEX_W
) (
  input logic                  clk,
  input logic                  rst,
  icache_direct_mapped_if.slave bus
);
  state_t                  state;
  logic                    mem_read_q;
  logic [MEM_ADDR_W-1:0]   line_addr;

  logic [INDEX_W-1:0]      req_index;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      fill_index;
  logic [TAG_W-1:0]        fill_tag;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_line;
  logic                    hit;
  logic                    fill_en;
  logic                    unused_inputs;

  assign req_index  = bus.proc_addr[INDEX_W+1:2];
  assign req_tag    = bus.proc_addr[PROC_ADDR_W-1:INDEX_W+2];
  assign fill_index = line_addr[INDEX_W-1:0];
  assign fill_tag   = line_addr[MEM_ADDR_W-1:INDEX_W];

  // The fill is driven from the latched line address, never the live proc_addr.
  assign fill_en = (state == ALLOCATE) && bus.mem_ready && !rst;

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fill_en),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_line  (bus.mem_rdata),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  assign hit = (state == COMPARE) && rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COMPARE;
      mem_read_q <= 1'b0;
    end else begin
      case (state)
        COMPARE: begin
          if (bus.proc_read && !hit) begin
            line_addr  <= bus.proc_addr[PROC_ADDR_W-1:2];
            mem_read_q <= 1'b1;
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            mem_read_q <= 1'b0;
            state      <= COMPARE;
          end
        end
        default: begin
          mem_read_q <= 1'b0;
          state      <= COMPARE;
        end
      endcase
    end
  end

  assign bus.proc_rdata = rd_line[{bus.proc_addr[1:0], 5'b0} +: WORD_W];
  assign bus.proc_stall = (state == ALLOCATE) || (bus.proc_read && !hit);
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;
  assign bus.mem_addr   = (state == ALLOCATE) ? line_addr
                                              : bus.proc_addr[PROC_ADDR_W-1:2];

  // Write-side fetch inputs have no function in a read-only cache.
  assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: misses, hits, eviction, latency, reset mid-fill.
module tb_icache_direct_mapped;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  icache_direct_mapped_if bus ();

  icache_direct_mapped #(.NUM_BLOCKS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: word k of line la = ((la-1) << 16) | (k << 8) | 0x13.
  function automatic logic [31:0] word_of(input logic [27:0] la, input int k);
    logic [31:0] la32;
    la32 = {4'b0, la};
    return ((la32 - 32'd1) << 16) | (32'(k) << 8) | 32'h13;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of(la, k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch; on a miss, answer the refill after lat ALLOCATE cycles.
  task automatic fetch(input logic [29:0] addr, input logic [31:0] exp,
                       input bit miss, input int lat, input string tag);
    bus.proc_read = 1'b1;
    bus.proc_addr = addr;
    @(negedge clk);
    check({tag, ".stall"}, 128'(bus.proc_stall), 128'(miss));
    check({tag, ".mem_read0"}, 128'(bus.mem_read), 128'd0);
    if (!miss) begin
      check({tag, ".rdata"}, 128'(bus.proc_rdata), 128'(exp));
      tick();
      return;
    end
    tick();
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line_of(addr[29:2]);
      end
      @(negedge clk);
      check({tag, ".mem_read_hi"}, 128'(bus.mem_read), 128'd1);
      check({tag, ".mem_addr"}, 128'(bus.mem_addr), 128'(addr[29:2]));
      check({tag, ".stall_alloc"}, 128'(bus.proc_stall), 128'd1);
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end
    @(negedge clk);
    check({tag, ".mem_read_drop"}, 128'(bus.mem_read), 128'd0);
    check({tag, ".retry_stall"}, 128'(bus.proc_stall), 128'd0);
    check({tag, ".retry_rdata"}, 128'(bus.proc_rdata), 128'(exp));
    tick();
  endtask

  initial begin
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset.stall", 128'(bus.proc_stall), 128'd0);
    check("reset.mem_read", 128'(bus.mem_read), 128'd0);
    check("reset.mem_write", 128'(bus.mem_write), 128'd0);
    check("reset.mem_wdata", bus.mem_wdata, 128'd0);
    tick();

    // Cold miss, memory answers after 4 cycles
    fetch(30'h0000_0004, 32'h0000_0013, 1'b1, 4, "cold");
    // Same-line hits
    fetch(30'h0000_0005, 32'h0000_0113, 1'b0, 0, "hit1");
    fetch(30'h0000_0006, 32'h0000_0213, 1'b0, 0, "hit2");
    fetch(30'h0000_0007, 32'h0000_0313, 1'b0, 0, "hit3");

    // Conflict eviction on index 0
    fetch(30'h0000_0000, 32'hFFFF_0013, 1'b1, 2, "conf_a");
    fetch(30'h0000_0020, 32'h0007_0013, 1'b1, 2, "conf_b");
    fetch(30'h0000_0000, 32'hFFFF_0013, 1'b1, 2, "conf_a2");

    // Variable memory latency
    fetch(30'h0000_0008, 32'h0001_0013, 1'b1, 1, "lat1");
    fetch(30'h0000_0011, 32'h0003_0113, 1'b1, 7, "lat7");
    fetch(30'h0000_001E, 32'h0006_0213, 1'b1, 20, "lat20");

    // Writes are ignored
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h0000_0006;
    bus.proc_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("write.mem_write", 128'(bus.mem_write), 128'd0);
    check("write.mem_read", 128'(bus.mem_read), 128'd0);
    check("write.stall", 128'(bus.proc_stall), 128'd0);
    tick();
    bus.proc_write = 1'b0;
    bus.proc_wdata = '0;
    fetch(30'h0000_0006, 32'h0000_0213, 1'b0, 0, "write_rd");

    // Reset mid-fill: miss on 0x40, abandon the refill after two ALLOCATE cycles
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h0000_0040;
    @(negedge clk);
    check("rstfill.miss", 128'(bus.proc_stall), 128'd1);
    tick();
    tick();
    @(negedge clk);
    check("rstfill.mem_read_hi", 128'(bus.mem_read), 128'd1);
    rst = 1'b1;
    bus.proc_read = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstfill.mem_read_lo", 128'(bus.mem_read), 128'd0);
    check("rstfill.stall", 128'(bus.proc_stall), 128'd0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = line_of(28'h000_0010);
    @(negedge clk);
    check("late_ready.mem_read", 128'(bus.mem_read), 128'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    fetch(30'h0000_0004, 32'h0000_0013, 1'b1, 3, "after_rst");
    fetch(30'h0000_0040, 32'h000F_0013, 1'b1, 2, "late_ignored");

    bus.proc_read = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
